// File: rtl/ram_march_bist.sv
// March BIST initiator for a 64x8 single-port synchronous RAM.
// Runs {up w(P)}, {up r(P) w(~P)}, {down r(~P)} and reports the error count and first failure.
module ram_march_bist #(
  parameter int                ADDR_W  = 6,
  parameter int                DATA_W  = 8,
  parameter int                DEPTH   = 64,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [2:0] {IDLE, FILL, RDWR, RDDN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] PAT_INV = ~PATTERN;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic                sub, sub_nxt;
  logic                accept;
  logic                chk_en;
  logic [DATA_W-1:0]   chk_exp;
  logic [ADDR_W-1:0]   chk_addr;
  logic                mis;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    sub_nxt   = sub;
    accept    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    chk_en    = 1'b0;
    chk_exp   = PATTERN;
    chk_addr  = addr;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = FILL;
          addr_nxt  = '0;
          sub_nxt   = 1'b0;
        end
      end
      FILL: begin
        ram_wr   = 1'b1;
        ram_addr = addr;
        ram_din  = PATTERN;
        if (addr == LAST) begin
          state_nxt = RDWR;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
      RDWR: begin
        ram_addr = addr;
        sub_nxt  = ~sub;
        if (sub) begin
          // Read issued last cycle lands now; overwrite the same word with ~P.
          ram_wr  = 1'b1;
          ram_din = PAT_INV;
          chk_en  = 1'b1;
          chk_exp = PATTERN;
          if (addr == LAST) state_nxt = RDDN;
          else              addr_nxt  = addr + 1'b1;
        end
      end
      RDDN: begin
        ram_addr = addr;
        // Data arriving now belongs to the previous (higher) address.
        chk_en   = (addr != LAST);
        chk_exp  = PAT_INV;
        chk_addr = addr + 1'b1;
        if (addr == '0) state_nxt = DRAIN;
        else            addr_nxt  = addr - 1'b1;
      end
      DRAIN: begin
        chk_en    = 1'b1;
        chk_exp   = PAT_INV;
        chk_addr  = '0;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mis = chk_en && (ram_dout != chk_exp);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      sub       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      sub   <= sub_nxt;
      if (accept) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        pass      <= 1'b0;
        err_cnt   <= '0;
        fail_addr <= '0;
        fail_data <= '0;
      end else begin
        if (mis) begin
          err_cnt <= err_cnt + 8'd1;
          if (err_cnt == '0) begin
            fail_addr <= chk_addr;
            fail_data <= ram_dout;
          end
        end
        if (state == DRAIN) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_cnt == '0) && !mis;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Self-checking bench for ram_march_bist: behavioural RAM with per-address stuck-at masks,
// table of fault scenarios with hand-computed results, plus reset and handshake sequences.
module tb_ram_march_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ram_wr;
  logic [5:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [5:0] fail_addr;
  logic [7:0] fail_data;

  int errors = 0;
  int checks = 0;

  ram_march_bist dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  // RAM model: registered read (read-before-write), stuck-at faults applied on the read path.
  logic [7:0] mem   [64];
  logic [7:0] and_m [64];
  logic [7:0] or_m  [64];

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    ram_dout <= (mem[ram_addr] & and_m[ram_addr]) | or_m[ram_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected RAM port for busy cycle n (0-based from the first FILL cycle).
  task automatic exp_port(input int n, output logic wr, output logic [5:0] a, output logic [7:0] d);
    int k;
    d = 8'h00;
    if (n < 64) begin
      wr = 1'b1; a = 6'(n); d = 8'h55;
    end else if (n < 192) begin
      k = n - 64; a = 6'(k / 2); wr = k[0]; d = 8'hAA;
    end else if (n < 256) begin
      wr = 1'b0; a = 6'(63 - (n - 192));
    end else begin
      wr = 1'b0; a = 6'd0;
    end
  endtask

  typedef struct {
    string      name;
    logic [5:0] fa0;
    logic [5:0] fa1;
    bit         two;
    logic [7:0] am;
    logic [7:0] om;
    bit         poke;
    int         exp_busy;
    logic [7:0] exp_err;
    logic [5:0] exp_faddr;
    logic [7:0] exp_fdata;
    bit         exp_pass;
  } vec_t;

  task automatic set_faults(input vec_t v);
    for (int i = 0; i < 64; i++) begin
      and_m[i] = 8'hFF;
      or_m[i]  = 8'h00;
    end
    and_m[v.fa0] = v.am;
    or_m[v.fa0]  = v.om;
    if (v.two) begin
      and_m[v.fa1] = v.am;
      or_m[v.fa1]  = v.om;
    end
  endtask

  task automatic run_test(input vec_t v);
    int n;
    int perr;
    logic       ew;
    logic [5:0] ea;
    logic [7:0] ed;
    set_faults(v);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({v.name, " start_clear"}, {busy, done, pass, err_cnt}, {1'b1, 1'b0, 1'b0, 8'h00});
    n = 0;
    perr = 0;
    while (busy && n < 400) begin
      exp_port(n, ew, ea, ed);
      if (ram_wr !== ew || ram_addr !== ea || (ew && ram_din !== ed)) begin
        if (perr == 0)
          $display("port deviation %s cycle %0d: wr=%0b addr=%0h din=%0h want wr=%0b addr=%0h din=%0h",
                   v.name, n, ram_wr, ram_addr, ram_din, ew, ea, ed);
        perr++;
      end
      n++;
      start = (v.poke && n == 50);
      @(negedge clk);
    end
    start = 1'b0;
    check({v.name, " busy_cycles"}, 64'(n), 64'(v.exp_busy));
    check({v.name, " port_seq"}, 64'(perr), 64'd0);
    check({v.name, " done"}, {63'd0, done}, 64'd1);
    check({v.name, " pass"}, {63'd0, pass}, {63'd0, v.exp_pass});
    check({v.name, " err_cnt"}, {56'd0, err_cnt}, {56'd0, v.exp_err});
    check({v.name, " fail_addr"}, {58'd0, fail_addr}, {58'd0, v.exp_faddr});
    check({v.name, " fail_data"}, {56'd0, fail_data}, {56'd0, v.exp_fdata});
  endtask

  function automatic logic [39:0] all_outs();
    return {ram_wr, ram_addr, ram_din, busy, done, pass, err_cnt, fail_addr, fail_data};
  endfunction

  vec_t vecs [6];

  initial begin
    //          name        fa0    fa1    two  and    or     poke busy err    faddr  fdata  pass
    vecs[0] = '{"clean",    6'h00, 6'h00, 0,   8'hFF, 8'h00, 0,   257, 8'd0, 6'h00, 8'h00, 1};
    vecs[1] = '{"sa0_b0@10", 6'h10, 6'h00, 0,  8'hFE, 8'h00, 0,   257, 8'd1, 6'h10, 8'h54, 0};
    vecs[2] = '{"sa1_b7@05,3F", 6'h05, 6'h3F, 1, 8'hFF, 8'h80, 0, 257, 8'd2, 6'h05, 8'hD5, 0};
    vecs[3] = '{"start_poke", 6'h00, 6'h00, 0, 8'hFF, 8'h00, 1,   257, 8'd0, 6'h00, 8'h00, 1};
    vecs[4] = '{"sa0_all@00", 6'h00, 6'h00, 0, 8'h00, 8'h00, 0,   257, 8'd2, 6'h00, 8'h00, 0};
    vecs[5] = '{"sa0_b1@3F", 6'h3F, 6'h00, 0,  8'hFD, 8'h00, 0,   257, 8'd1, 6'h3F, 8'hA8, 0};

    rst = 1'b0;
    start = 1'b0;
    set_faults(vecs[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {24'd0, all_outs()}, 64'd0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_quiet", {24'd0, all_outs()}, 64'd0);

    for (int i = 0; i < 6; i++) run_test(vecs[i]);

    // Asynchronous reset in RDWR after address 0x10 has already miscompared.
    set_faults(vecs[1]);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    check("pre_reset_err", {56'd0, err_cnt}, 64'd1);
    check("pre_reset_faddr", {58'd0, fail_addr}, 64'h10);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", {24'd0, all_outs()}, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {24'd0, all_outs()}, 64'd0);
    run_test(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Built-in self-test initiator for the 64 x 8 single-port synchronous RAM.
- Drives the RAM's wr/address/din port and checks its registered dout with a 3-element march test:
  - ascending write P;
  - ascending read P, then write ~P;
  - descending read ~P.
- Sits beside the RAM and takes over its port during power-on test.
- Reports pass/fail, error count and the first failing address and data.

Parameters:
- ADDR_W, 6, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 64, number of words tested. Must equal 2**ADDR_W.
- PATTERN, 8'h55, background pattern P. The inverse pattern is ~P.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run the test. Sampled only in IDLE.
- ram_wr  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM read data. Registered in the RAM, valid the cycle after a read is issued.
- busy  output  1  test in progress.
- done  output  1  test complete. Held until the next accepted start or reset.
- pass  output  1  valid when done=1. High means err_cnt==0.
- err_cnt  output  8  number of miscompares. Maximum is 128.
- fail_addr  output  ADDR_W  address of the first miscompare.
- fail_data  output  DATA_W  data read at the first miscompare.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state goes to IDLE;
  - counters cleared;
  - ram_wr, ram_addr, ram_din, busy, done, pass, err_cnt, fail_addr and fail_data all go to 0.
- Reset mid-test aborts the test. RAM contents are then undefined.
- Port decode:
  - ram_wr, ram_addr and ram_din are decoded from the registered state, address counter and sub-phase bit only;
  - they do not depend combinationally on ram_dout or start.
  - In IDLE and DONE: ram_wr=0, ram_addr=0, ram_din=0.
- States: IDLE, FILL, RDWR, RDDN, DRAIN, DONE.
- IDLE:
  - start=1 at an edge moves to FILL, clears err_cnt/fail_addr/fail_data/done/pass, sets busy=1 and sets the address counter to 0.
- FILL:
  - one write per cycle: ram_wr=1, ram_addr=a, ram_din=P, for a = 0..63 ascending;
  - after a=63, go to RDWR with a=0. Takes 64 cycles.
- RDWR, two cycles per address:
  - sub-phase 0: ram_wr=0, ram_addr=a (read issued);
  - sub-phase 1: ram_wr=1, ram_addr=a, ram_din=~P, and ram_dout is compared with P in the same cycle;
  - after a=63 sub-phase 1, go to RDDN with a=63. Takes 128 cycles.
- RDDN:
  - one read per cycle: ram_wr=0, ram_addr=a, for a = 63..0 descending;
  - starting from the second RDDN cycle, ram_dout is compared with ~P and attributed to address a+1 (one-cycle pipeline);
  - after a=0, go to DRAIN.
- DRAIN:
  - ram_wr=0, ram_addr=0;
  - compares the read of address 0 against ~P;
  - then goes to DONE.
- Total run: 64 + 128 + 64 + 1 = 257 busy cycles from the first FILL cycle to the DRAIN cycle inclusive.
- On a miscompare:
  - err_cnt increments;
  - if err_cnt was 0 before the increment, fail_addr and fail_data are captured.
  - Later failures never overwrite the captured values.
- DONE:
  - busy=0, done=1, pass=(err_cnt==0);
  - start=1 here starts a new run exactly as from IDLE.
- start while busy=1 is ignored: no restart, no effect on counters.
- Address counter wraps are never exercised. State transitions happen on the terminal counts 63 and 0 only.

Test Plan:
- Fault-free RAM model, P=0x55, pulse start:
  - busy high for exactly 257 cycles, then done=1, pass=1, err_cnt=0;
  - first 64 cycles show ram_wr=1 with ram_din=0x55 at addresses 0..63.
- RAM model with bit 0 stuck at 0 at address 0x10:
  - RDWR read returns 0x54, so err_cnt=1, fail_addr=0x10, fail_data=0x54;
  - RDDN read of ~P=0xAA matches;
  - final pass=0.
- Stuck-at-1 bit 7 at addresses 0x05 and 0x3F:
  - RDDN reads return 0xAA, which matches, so there are no RDDN errors;
  - RDWR reads return 0xD5 (two errors);
  - err_cnt=2, fail_addr=0x05 (first in ascending order), fail_data=0xD5.
- Address-order check:
  - in RDDN, ram_addr sequence is 63,62,...,0 with ram_wr=0;
  - in RDWR, each address appears twice, as (wr=0, wr=1 din=0xAA).
- Handshake:
  - start pulsed at busy cycle 50 is ignored, and total busy is still 257;
  - start in DONE clears done/pass/err_cnt and reruns.
- rst driven low asynchronously mid-edge at busy cycle 100:
  - all outputs are 0 immediately, state is IDLE;
  - after release, start gives a clean 257-cycle pass.
